stopwatch_ctrl: RTL and testbench

Stopwatch controller for the digital clock. Generates its own 10 ms tick from the system clock and runs a start/stop/lap/clear state machine. Keeps a mm:ss.cc count and drives the values shown on the stopwatch display. Button inputs arrive as debounced single-cycle pulses from the button front end.

---
 rtl/stopwatch_ctrl_if.sv | 24 ++
 rtl/stopwatch_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch controller bus: debounced button pulses in, display and status out.
// Control pulses carry no valid/ready pair: each high cycle is one request and is always accepted.
interface stopwatch_ctrl_if;
    logic       start_stop;
    logic       lap_reset;
    logic [6:0] disp_cs;
    logic [5:0] disp_sec;
    logic [5:0] disp_min;
    logic       running;
    logic       frozen;
    logic       ovf;
    logic       tick;
    logic [1:0] state;

    modport master (
        output start_stop, lap_reset,
        input  disp_cs, disp_sec, disp_min, running, frozen, ovf, tick, state
    );

    modport slave (
        input  start_stop, lap_reset,
        output disp_cs, disp_sec, disp_min, running, frozen, ovf, tick, state
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: centisecond prescaler, mm:ss.cc count chain, start/stop/lap/clear FSM.
// Define SW_LAP_EN to build the LAP state and lap capture registers.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 1000000,
    parameter int CNT_W    = 20
) (
    input logic clk,
    input logic rst,
    stopwatch_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    state_t           state_q;
    logic [CNT_W-1:0] presc_q;
    logic [6:0]       cs_q, cs_n;
    logic [5:0]       sec_q, sec_n;
    logic [5:0]       min_q, min_n;
    logic             wrap;
    logic             ovf_q;
    logic             running_q;
    logic             tick_w;

    // running_q mirrors RUN||LAP, so the prescaler only advances while counting.
    assign tick_w = running_q && (presc_q == LAST);

    always_comb begin
        cs_n  = cs_q;
        sec_n = sec_q;
        min_n = min_q;
        wrap  = 1'b0;
        if (tick_w) begin
            if (cs_q == 7'd99) begin
                cs_n = 7'd0;
                if (sec_q == 6'd59) begin
                    sec_n = 6'd0;
                    if (min_q == 6'd59) begin
                        min_n = 6'd0;
                        wrap  = 1'b1;
                    end else begin
                        min_n = min_q + 6'd1;
                    end
                end else begin
                    sec_n = sec_q + 6'd1;
                end
            end else begin
                cs_n = cs_q + 7'd1;
            end
        end
    end

`ifdef SW_LAP_EN
    logic [6:0] lap_cs_q;
    logic [5:0] lap_sec_q;
    logic [5:0] lap_min_q;
    logic       frozen_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            cs_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
            frozen_q  <= 1'b0;
            lap_cs_q  <= '0;
            lap_sec_q <= '0;
            lap_min_q <= '0;
        end else begin
            if (running_q) presc_q <= tick_w ? '0 : presc_q + 1'b1;
            cs_q  <= cs_n;
            sec_q <= sec_n;
            min_q <= min_n;
            if (wrap) ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.start_stop) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN, LAP: begin
                    if (bus.start_stop) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                        frozen_q  <= 1'b0;
                    end else if (bus.lap_reset) begin
                        // Capture takes the post-tick value when the pulse lands on a tick.
                        state_q   <= LAP;
                        frozen_q  <= 1'b1;
                        lap_cs_q  <= cs_n;
                        lap_sec_q <= sec_n;
                        lap_min_q <= min_n;
                    end
                end
                PAUSE: begin
                    if (bus.start_stop) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (bus.lap_reset) begin
                        state_q   <= IDLE;
                        presc_q   <= '0;
                        cs_q      <= '0;
                        sec_q     <= '0;
                        min_q     <= '0;
                        ovf_q     <= 1'b0;
                        lap_cs_q  <= '0;
                        lap_sec_q <= '0;
                        lap_min_q <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.disp_cs  = frozen_q ? lap_cs_q  : cs_q;
    assign bus.disp_sec = frozen_q ? lap_sec_q : sec_q;
    assign bus.disp_min = frozen_q ? lap_min_q : min_q;
    assign bus.frozen   = frozen_q;
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            presc_q   <= '0;
            cs_q      <= '0;
            sec_q     <= '0;
            min_q     <= '0;
            ovf_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            if (running_q) presc_q <= tick_w ? '0 : presc_q + 1'b1;
            cs_q  <= cs_n;
            sec_q <= sec_n;
            min_q <= min_n;
            if (wrap) ovf_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.start_stop) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.start_stop) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (bus.start_stop) begin
                        state_q   <= RUN;
                        running_q <= 1'b1;
                    end else if (bus.lap_reset) begin
                        state_q <= IDLE;
                        presc_q <= '0;
                        cs_q    <= '0;
                        sec_q   <= '0;
                        min_q   <= '0;
                        ovf_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.disp_cs  = cs_q;
    assign bus.disp_sec = sec_q;
    assign bus.disp_min = min_q;
    assign bus.frozen   = 1'b0;
`endif

    assign bus.running = running_q;
    assign bus.ovf     = ovf_q;
    assign bus.tick    = tick_w;
    assign bus.state   = state_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button pulses against a
// centisecond-total reference model. Define SW_LAP_EN for both RTL and bench to cover laps.
module tb_stopwatch_ctrl;
    localparam int TD   = 4;
    localparam int WRAP = 60 * 60 * 100;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_LAP   = 2;
    localparam int M_PAUSE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    stopwatch_ctrl_if bus();

    stopwatch_ctrl #(.TICK_DIV(TD), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed time as one centisecond total.
    int m_state = M_IDLE;
    int m_total = 0;
    int m_phase = 0;
    int m_lap   = 0;
    int m_ovf   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int m_counting();
        return (m_state == M_RUN || m_state == M_LAP) ? 1 : 0;
    endfunction

    function automatic int m_shown();
        return (m_state == M_LAP) ? m_lap : m_total;
    endfunction

    task automatic model_step(input bit ss, input bit ls, input bit r);
        if (r) begin
            m_state = M_IDLE; m_total = 0; m_phase = 0; m_lap = 0; m_ovf = 0;
            return;
        end
        if (m_counting() != 0) begin
            if (m_phase == TD - 1) begin
                m_phase = 0;
                m_total = m_total + 1;
                if (m_total == WRAP) begin
                    m_total = 0;
                    m_ovf   = 1;
                end
            end else begin
                m_phase = m_phase + 1;
            end
        end
        case (m_state)
            M_IDLE:  if (ss) m_state = M_RUN;
            M_RUN, M_LAP: begin
                if (ss) m_state = M_PAUSE;
`ifdef SW_LAP_EN
                else if (ls) begin
                    m_state = M_LAP;
                    m_lap   = m_total;
                end
`endif
            end
            default: begin
                if (ss) m_state = M_RUN;
                else if (ls) begin
                    m_state = M_IDLE; m_total = 0; m_phase = 0; m_lap = 0; m_ovf = 0;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        int shown;
        shown = m_shown();
        check("disp_cs",  int'(bus.disp_cs),  shown % 100);
        check("disp_sec", int'(bus.disp_sec), (shown / 100) % 60);
        check("disp_min", int'(bus.disp_min), shown / 6000);
        check("running",  int'(bus.running),  m_counting());
        check("frozen",   int'(bus.frozen),   (m_state == M_LAP) ? 1 : 0);
        check("ovf",      int'(bus.ovf),      m_ovf);
        check("tick",     int'(bus.tick),     (m_counting() != 0 && m_phase == TD - 1) ? 1 : 0);
    endtask

    // Entered and left at a falling edge.
    task automatic cycle(input bit ss, input bit ls, input bit r);
        bus.start_stop = ss;
        bus.lap_reset  = ls;
        rst            = r;
        @(posedge clk);
        model_step(ss, ls, r);
        @(negedge clk);
        bus.start_stop = 1'b0;
        bus.lap_reset  = 1'b0;
        rst            = 1'b0;
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clear_and_start();
        if (m_state != M_IDLE) begin
            if (m_state != M_PAUSE) cycle(1'b1, 1'b0, 1'b0);
            cycle(1'b0, 1'b1, 1'b0);
        end
        cycle(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        int p;
        int n;
        bus.start_stop = 1'b0;
        bus.lap_reset  = 1'b0;
        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_cs", int'(bus.disp_cs), 0);
        check("reset_running", int'(bus.running), 0);

        // IDLE ignores lap_reset.
        run(3);
        cycle(1'b0, 1'b1, 1'b0);
        run(3);
        check("idle_lap_running", int'(bus.running), 0);
        check("idle_lap_cs", int'(bus.disp_cs), 0);

        // One second of counting.
        cycle(1'b1, 1'b0, 1'b0);
        run(400);
        check("1s_sec", int'(bus.disp_sec), 1);
        check("1s_cs", int'(bus.disp_cs), 0);
        check("1s_running", int'(bus.running), 1);

        // Pause mid-tick at 00:00.05 and confirm the sub-tick phase survives.
        clear_and_start();
        run(21);
        cycle(1'b1, 1'b0, 1'b0);
        p = m_phase;
        run(100);
        check("pause_cs", int'(bus.disp_cs), 5);
        check("pause_running", int'(bus.running), 0);
        cycle(1'b1, 1'b0, 1'b0);
        n = 0;
        while (bus.tick !== 1'b1 && n < 2 * TD) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("resume_phase", n, TD - 1 - p);

`ifdef SW_LAP_EN
        // Lap freeze at 00:00.10, then a second capture at 00:00.20.
        clear_and_start();
        run(39);
        cycle(1'b0, 1'b1, 1'b0);
        run(40);
        check("lap1_cs", int'(bus.disp_cs), 10);
        check("lap1_frozen", int'(bus.frozen), 1);
        cycle(1'b0, 1'b1, 1'b0);
        check("lap2_cs", int'(bus.disp_cs), 20);
        cycle(1'b1, 1'b0, 1'b0);
        check("lap_pause_frozen", int'(bus.frozen), 0);
`else
        clear_and_start();
        run(39);
        cycle(1'b0, 1'b1, 1'b0);
        run(40);
        check("nolap_cs", int'(bus.disp_cs), 20);
        check("nolap_running", int'(bus.running), 1);
        cycle(1'b1, 1'b0, 1'b0);
`endif

        // Overflow: preload 59:59.95 while paused, resume and roll over.
        force dut.cs_q  = 7'd95;
        force dut.sec_q = 6'd59;
        force dut.min_q = 6'd59;
        @(posedge clk);
        #1;
        release dut.cs_q;
        release dut.sec_q;
        release dut.min_q;
        m_total = WRAP - 5;
        @(negedge clk);
        check_outputs();
        cycle(1'b1, 1'b0, 1'b0);
        n = 0;
        while (bus.ovf !== 1'b1 && n < 8 * TD) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("wrap_ovf", int'(bus.ovf), 1);
        check("wrap_min", int'(bus.disp_min), 0);
        check("wrap_cs", int'(bus.disp_cs), 0);
        run(10);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        check("clear_ovf", int'(bus.ovf), 0);

        // Simultaneous pulses in RUN: pause wins, no capture.
        cycle(1'b1, 1'b0, 1'b0);
        run(13);
        cycle(1'b1, 1'b1, 1'b0);
        check("both_running", int'(bus.running), 0);
        check("both_frozen", int'(bus.frozen), 0);

        // Reset mid-run.
        cycle(1'b1, 1'b0, 1'b0);
        run(9);
        cycle(1'b0, 1'b0, 1'b1);
        check("midrun_rst_cs", int'(bus.disp_cs), 0);
        check("midrun_rst_running", int'(bus.running), 0);

        // Random pulses, including pulses landing on tick cycles and stray resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 299) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
